axil_gpio_regs: RTL and testbench
=================================

// Module: axil_gpio_regs
// PURPOSE
//  Parametrised AXI4-Lite control/status register block; next generation of the tile's write-only GPIO device.
//  Provides NUM_REGS read/write registers with byte strobes, one read-only status word and per-register write pulses.
//  Full read support, AW/W accepted independently, SLVERR decode. Register 0 bit 0 drives CPU resetn in the tile.
// PARAMETERS
//  DATA_WIDTH   32  AXI data width in bits; multiple of 8.
//  ADDR_WIDTH   8   AXI byte-address width.
//  NUM_REGS     4   number of RW registers (1..2**(ADDR_WIDTH-ADDR_LSB)-1).
//  RESET_VALUE  0   DATA_WIDTH-bit reset value loaded into every RW register.
// PORTS
//  clk            in   1                     clock
//  resetn         in   1                     synchronous, active-low reset
//  s_axil_awaddr  in   ADDR_WIDTH            write address
//  s_axil_awvalid/awready  in/out  1         AW handshake
//  s_axil_wdata   in   DATA_WIDTH            write data
//  s_axil_wstrb   in   DATA_WIDTH/8          byte-lane enables
//  s_axil_wvalid/wready    in/out  1         W handshake
//  s_axil_bresp   out  2                     00 OKAY, 10 SLVERR
//  s_axil_bvalid/bready    out/in  1         B handshake
//  s_axil_araddr  in   ADDR_WIDTH            read address
//  s_axil_arvalid/arready  in/out  1         AR handshake
//  s_axil_rdata   out  DATA_WIDTH            read data
//  s_axil_rresp   out  2                     00 OKAY, 10 SLVERR
//  s_axil_rvalid/rready    out/in  1         R handshake
//  gpio_out       out  NUM_REGS*DATA_WIDTH   register i at [i*DATA_WIDTH +: DATA_WIDTH]
//  gpio_in        in   DATA_WIDTH            status word, same clock domain
//  gpio_wr_pulse  out  NUM_REGS              1-cycle pulse per OKAY write to register i
// BEHAVIOUR
//  Reset (resetn low): regs=RESET_VALUE; bvalid, rvalid, bresp, rresp, rdata, gpio_wr_pulse = 0; AW/W slots empty.
//   awready/wready/arready low while resetn low and the first cycle after release (registered rst_q flag).
//   Reset mid-operation discards held AW/W and pending B/R; no response is ever issued for them.
//  Decode: idx = addr[ADDR_WIDTH-1:ADDR_LSB], ADDR_LSB = clog2(DATA_WIDTH/8); low address bits ignored.
//   idx<NUM_REGS: RW. idx==NUM_REGS: RO status (read gpio_in). Otherwise unmapped.
//  Write: awready = !aw_full; wready = !w_full; each handshake fills its one-entry slot, in any order/cycle.
//   Commit edge: aw_full && w_full && (!bvalid || bready). At that edge: byte lanes with wstrb=1 updated,
//   slots cleared, bvalid<=1, bresp set; gpio_wr_pulse[idx]<=1 for exactly one cycle (OKAY only, even wstrb=0).
//   Latency: AW+W accepted at edge N -> commit/bvalid at edge N+1. Throughput 1 write per 2 cycles.
//   Write to status or unmapped idx: SLVERR, no register change, no pulse.
//   bvalid holds until bready; a second AW/W may be held meanwhile and commits on the bready edge.
//  Read: arready = !rvalid && !rst_q. AR handshake at edge N -> rvalid, rdata, rresp at N+1; held until rready.
//   One outstanding read. RW idx: register value; status: gpio_in sampled at edge N; unmapped: rdata 0, SLVERR.
//  Simultaneous read and write commit to same register on one edge: read returns the pre-write value.
//  Read and write paths independent; neither stalls the other.
// STRUCTURE
//  Package axil_gpio_regs_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, clog2-based ADDR_LSB function.
//  Sub-module axil_hold_slot (param WIDTH): one-entry valid/ready holding register, instantiated for AW and W.
//  Register array, strobe merge, decode and R/B response logic in top level.
// TESTING (DATA_WIDTH=32, ADDR_WIDTH=8, NUM_REGS=4, RESET_VALUE=0 unless noted)
//  Reset 4 cycles -> gpio_out=0, bvalid=rvalid=0, readies 0 until 2nd cycle after release; RESET_VALUE=1 -> reg0=1.
//  AW 0x04 at cycle 0, W 0xDEADBEEF/4'hF at cycle 3 -> bvalid next edge, OKAY, gpio_out[63:32]=DEADBEEF, pulse=4'b0010 once.
//  Reg0=0xAAAAAAAA, write 0x11223344 wstrb 4'b0101 -> reg0=0xAA22AA44; read 0x00 returns 0xAA22AA44 OKAY.
//  gpio_in=0x5A5A: read 0x10 -> 0x5A5A OKAY; write 0x10 -> SLVERR, no change/pulse; read 0x14 -> 0, SLVERR.
//  bready low 5 cycles after write A; issue write B -> B held, not committed; bready high -> A completes, B next.
//  resetn low while AW held and rvalid high -> after release no bvalid/rvalid, regs=RESET_VALUE, random traffic resumes.

Source files
------------

// File: rtl/axil_gpio_regs_pkg.sv
// Shared response codes and address-decode helper for the AXI4-Lite GPIO register block.
package axil_gpio_regs_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic int addr_lsb(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/axil_hold_slot.sv
// One-entry valid/ready holding register; captures a beat and keeps it until the owner clears it.
module axil_hold_slot
  import axil_gpio_regs_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_block,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_clear,
  output logic             o_full,
  output logic [WIDTH-1:0] o_data
);

  logic             r_full;
  logic [WIDTH-1:0] r_data;

  assign o_ready = !r_full && !i_block;
  assign o_full  = r_full;
  assign o_data  = r_data;

  // Clear and accept never coincide: clear needs the slot full, accept needs it empty.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (i_clear) begin
      r_full <= 1'b0;
    end else if (i_valid && o_ready) begin
      r_full <= 1'b1;
      r_data <= i_data;
    end
  end

endmodule

// File: rtl/axil_gpio_regs.sv
// AXI4-Lite control/status register block: NUM_REGS RW registers, one RO status word, write pulses.
module axil_gpio_regs
  import axil_gpio_regs_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 8,
  parameter int                    NUM_REGS    = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic [ADDR_WIDTH-1:0]          s_axil_awaddr,
  input  logic                           s_axil_awvalid,
  output logic                           s_axil_awready,
  input  logic [DATA_WIDTH-1:0]          s_axil_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s_axil_wstrb,
  input  logic                           s_axil_wvalid,
  output logic                           s_axil_wready,
  output logic [1:0]                     s_axil_bresp,
  output logic                           s_axil_bvalid,
  input  logic                           s_axil_bready,
  input  logic [ADDR_WIDTH-1:0]          s_axil_araddr,
  input  logic                           s_axil_arvalid,
  output logic                           s_axil_arready,
  output logic [DATA_WIDTH-1:0]          s_axil_rdata,
  output logic [1:0]                     s_axil_rresp,
  output logic                           s_axil_rvalid,
  input  logic                           s_axil_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] gpio_out,
  input  logic [DATA_WIDTH-1:0]          gpio_in,
  output logic [NUM_REGS-1:0]            gpio_wr_pulse
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = addr_lsb(DATA_WIDTH);
  localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
  localparam logic [IDX_W-1:0] STATUS_IDX = IDX_W'(NUM_REGS);

  logic                  r_rst_q;
  logic                  w_block;
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]   r_wr_pulse;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic                  r_rvalid;
  logic [1:0]            r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                     w_aw_full;
  logic [IDX_W-1:0]         w_aw_idx;
  logic                     w_w_full;
  logic [STRB_W-1:0]        w_strb;
  logic [DATA_WIDTH-1:0]    w_wdata;
  logic                     w_commit;
  logic                     w_wr_ok;
  logic [IDX_W-1:0]         w_ar_idx;
  logic                     w_ar_hs;
  logic [DATA_WIDTH-1:0]    w_rd_data;
  logic [1:0]               w_rd_resp;

  // Handshakes stay closed during reset and for the first cycle after release.
  always_ff @(posedge clk) begin
    if (!resetn) r_rst_q <= 1'b1;
    else         r_rst_q <= 1'b0;
  end

  assign w_block = !resetn || r_rst_q;

  axil_hold_slot #(.WIDTH(IDX_W)) u_aw_slot (
    .clk     (clk),
    .resetn  (resetn),
    .i_block (w_block),
    .i_valid (s_axil_awvalid),
    .o_ready (s_axil_awready),
    .i_data  (s_axil_awaddr[ADDR_WIDTH-1:ADDR_LSB]),
    .i_clear (w_commit),
    .o_full  (w_aw_full),
    .o_data  (w_aw_idx)
  );

  axil_hold_slot #(.WIDTH(STRB_W + DATA_WIDTH)) u_w_slot (
    .clk     (clk),
    .resetn  (resetn),
    .i_block (w_block),
    .i_valid (s_axil_wvalid),
    .o_ready (s_axil_wready),
    .i_data  ({s_axil_wstrb, s_axil_wdata}),
    .i_clear (w_commit),
    .o_full  (w_w_full),
    .o_data  ({w_strb, w_wdata})
  );

  generate
    if (ADDR_LSB > 0) begin : g_unused_lsb
      logic w_unused_lsb;
      assign w_unused_lsb = ^{s_axil_awaddr[ADDR_LSB-1:0], s_axil_araddr[ADDR_LSB-1:0]};
    end
  endgenerate

  assign w_commit = w_aw_full && w_w_full && (!r_bvalid || s_axil_bready);
  assign w_wr_ok  = w_aw_idx < STATUS_IDX;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VALUE;
    end else if (w_commit && w_wr_ok) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_aw_idx == IDX_W'(i)) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (w_strb[b]) r_regs[i][b*8 +: 8] <= w_wdata[b*8 +: 8];
          end
        end
      end
    end
  end

  // A pulse fires for every OKAY commit, even one whose strobes are all zero.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_pulse <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        r_wr_pulse[i] <= w_commit && w_wr_ok && (w_aw_idx == IDX_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_bvalid <= 1'b0;
      r_bresp  <= RESP_OKAY;
    end else if (w_commit) begin
      r_bvalid <= 1'b1;
      r_bresp  <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (s_axil_bready) begin
      r_bvalid <= 1'b0;
    end
  end

  assign w_ar_idx       = s_axil_araddr[ADDR_WIDTH-1:ADDR_LSB];
  assign s_axil_arready = !w_block && !r_rvalid;
  assign w_ar_hs        = s_axil_arvalid && s_axil_arready;

  always_comb begin
    w_rd_data = '0;
    w_rd_resp = RESP_SLVERR;
    if (w_ar_idx == STATUS_IDX) begin
      w_rd_data = gpio_in;
      w_rd_resp = RESP_OKAY;
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_ar_idx == IDX_W'(i)) begin
        w_rd_data = r_regs[i];
        w_rd_resp = RESP_OKAY;
      end
    end
  end

  // Reads sample the array before any same-edge commit lands, so they see the old value.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_data;
      r_rresp  <= w_rd_resp;
    end else if (s_axil_rready) begin
      r_rvalid <= 1'b0;
    end
  end

  generate
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
      assign gpio_out[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
    end
  endgenerate

  assign s_axil_bvalid = r_bvalid;
  assign s_axil_bresp  = r_bresp;
  assign s_axil_rvalid = r_rvalid;
  assign s_axil_rresp  = r_rresp;
  assign s_axil_rdata  = r_rdata;
  assign gpio_wr_pulse = r_wr_pulse;

endmodule

// File: tb/tb_axil_gpio_regs.sv
// Directed and random scoreboard bench for axil_gpio_regs with a small register model.
module tb_axil_gpio_regs;

  logic         clk = 1'b0;
  logic         resetn;
  logic [7:0]   awaddr;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wvalid;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;
  logic [7:0]   araddr;
  logic         arvalid;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready;
  logic [127:0] gpioOut;
  logic [31:0]  gpioIn;
  logic [3:0]   pulse;

  logic         idleAwready, idleWready, idleArready, idleBvalid, idleRvalid;
  logic [1:0]   idleBresp, idleRresp;
  logic [31:0]  idleRdata;
  logic [127:0] rv1GpioOut;
  logic [3:0]   idlePulse;
  logic [31:0]  zeroWord = 32'h0;

  typedef struct { logic [1:0] resp; logic [3:0] pulse; } bExp_t;
  typedef struct { logic [31:0] data; logic [1:0] resp; } rExp_t;
  bExp_t bq[$];
  rExp_t rq[$];
  logic [31:0] mdl [4];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  axil_gpio_regs #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_REGS(4), .RESET_VALUE(32'h0)) dut (
    .clk(clk), .resetn(resetn),
    .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
    .gpio_out(gpioOut), .gpio_in(gpioIn), .gpio_wr_pulse(pulse)
  );

  axil_gpio_regs #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_REGS(4), .RESET_VALUE(32'h1)) dutRv1 (
    .clk(clk), .resetn(resetn),
    .s_axil_awaddr(8'h0), .s_axil_awvalid(1'b0), .s_axil_awready(idleAwready),
    .s_axil_wdata(zeroWord), .s_axil_wstrb(4'h0), .s_axil_wvalid(1'b0), .s_axil_wready(idleWready),
    .s_axil_bresp(idleBresp), .s_axil_bvalid(idleBvalid), .s_axil_bready(1'b1),
    .s_axil_araddr(8'h0), .s_axil_arvalid(1'b0), .s_axil_arready(idleArready),
    .s_axil_rdata(idleRdata), .s_axil_rresp(idleRresp), .s_axil_rvalid(idleRvalid), .s_axil_rready(1'b1),
    .gpio_out(rv1GpioOut), .gpio_in(zeroWord), .gpio_wr_pulse(idlePulse)
  );

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [127:0] packModel();
    return {mdl[3], mdl[2], mdl[1], mdl[0]};
  endfunction

  task automatic expectWrite(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
    bExp_t e;
    int idx;
    idx = int'(addr[7:2]);
    if (idx < 4) begin
      e.resp  = 2'b00;
      e.pulse = 4'(1 << idx);
      for (int b = 0; b < 4; b++)
        if (strb[b]) mdl[idx][b*8 +: 8] = data[b*8 +: 8];
    end else begin
      e.resp  = 2'b10;
      e.pulse = 4'h0;
    end
    bq.push_back(e);
  endtask

  task automatic expectRead(input logic [7:0] addr);
    rExp_t e;
    int idx;
    idx = int'(addr[7:2]);
    if (idx < 4) begin
      e.data = mdl[idx];  e.resp = 2'b00;
    end else if (idx == 4) begin
      e.data = gpioIn;    e.resp = 2'b00;
    end else begin
      e.data = 32'h0;     e.resp = 2'b10;
    end
    rq.push_back(e);
  endtask

  task automatic applyWrite(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input logic doAw, input logic doW);
    logic aH, wH;
    awaddr  = addr;
    wdata   = data;
    wstrb   = strb;
    awvalid = doAw;
    wvalid  = doW;
    for (int c = 0; c < 20 && (awvalid || wvalid); c++) begin
      aH = awvalid && awready;
      wH = wvalid && wready;
      tick();
      if (aH) awvalid = 1'b0;
      if (wH) wvalid  = 1'b0;
    end
    checkOutput("wr_accept", {awvalid, wvalid}, 2'b00);
    awvalid = 1'b0;
    wvalid  = 1'b0;
  endtask

  task automatic applyRead(input logic [7:0] addr);
    logic aH;
    araddr  = addr;
    arvalid = 1'b1;
    for (int c = 0; c < 20 && arvalid; c++) begin
      aH = arready;
      tick();
      if (aH) arvalid = 1'b0;
    end
    checkOutput("rd_accept", arvalid, 1'b0);
    arvalid = 1'b0;
  endtask

  task automatic collectB(input string tag);
    bExp_t e;
    for (int c = 0; c < 20 && !bvalid; c++) tick();
    checkOutput({tag, "_bvalid"}, bvalid, 1'b1);
    if (bq.size() > 0) begin
      e = bq.pop_front();
      if (bvalid) begin
        checkOutput({tag, "_bresp"}, bresp, e.resp);
        checkOutput({tag, "_pulse"}, pulse, e.pulse);
      end
    end
    tick();
  endtask

  task automatic collectR(input string tag);
    rExp_t e;
    for (int c = 0; c < 20 && !rvalid; c++) tick();
    checkOutput({tag, "_rvalid"}, rvalid, 1'b1);
    if (rq.size() > 0) begin
      e = rq.pop_front();
      if (rvalid) begin
        checkOutput({tag, "_rdata"}, rdata, e.data);
        checkOutput({tag, "_rresp"}, rresp, e.resp);
      end
    end
    tick();
  endtask

  initial begin
    logic [7:0]  rAddr;
    logic [31:0] rData;
    logic [3:0]  rStrb;
    int          idx;

    resetn  = 1'b0;
    awaddr  = 8'h0;  awvalid = 1'b0;
    wdata   = 32'h0; wstrb   = 4'h0; wvalid = 1'b0;
    araddr  = 8'h0;  arvalid = 1'b0;
    bready  = 1'b1;  rready  = 1'b1;
    gpioIn  = 32'h0;
    for (int i = 0; i < 4; i++) mdl[i] = 32'h0;

    // Reset behaviour and ready gating around release
    repeat (4) tick();
    checkOutput("rst_readies", {awready, wready, arready}, 3'b000);
    checkOutput("rst_valids", {bvalid, rvalid}, 2'b00);
    checkOutput("rst_gpio", gpioOut, 128'h0);
    checkOutput("rst_pulse", pulse, 4'h0);
    checkOutput("rst_rv1_gpio", rv1GpioOut, {4{32'h1}});
    resetn = 1'b1;
    #1;
    checkOutput("rel_readies_cycle1", {awready, wready, arready}, 3'b000);
    tick();
    checkOutput("rel_readies_cycle2", {awready, wready, arready}, 3'b111);

    // AW alone, W three cycles later, then B exactly one edge after W acceptance
    expectWrite(8'h04, 32'hDEADBEEF, 4'hF);
    applyWrite(8'h04, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0);
    tick(); tick();
    checkOutput("lat_aw_only_no_b", bvalid, 1'b0);
    applyWrite(8'h04, 32'hDEADBEEF, 4'hF, 1'b0, 1'b1);
    checkOutput("lat_b_not_early", bvalid, 1'b0);
    tick();
    checkOutput("lat_b_next_edge", bvalid, 1'b1);
    collectB("lat");
    checkOutput("lat_gpio_reg1", gpioOut[63:32], 32'hDEADBEEF);
    checkOutput("lat_pulse_once", pulse, 4'h0);

    // Byte strobes
    expectWrite(8'h00, 32'hAAAAAAAA, 4'hF);
    applyWrite(8'h00, 32'hAAAAAAAA, 4'hF, 1'b1, 1'b1);
    collectB("strb_full");
    expectWrite(8'h00, 32'h11223344, 4'b0101);
    applyWrite(8'h00, 32'h11223344, 4'b0101, 1'b1, 1'b1);
    collectB("strb_part");
    checkOutput("strb_reg0", gpioOut[31:0], 32'hAA22AA44);
    expectRead(8'h00);
    applyRead(8'h00);
    collectR("rd_reg0");

    // Status word, writes to it, unmapped accesses
    gpioIn = 32'h00005A5A;
    expectRead(8'h10);
    applyRead(8'h10);
    collectR("rd_status");
    expectWrite(8'h10, 32'hFFFFFFFF, 4'hF);
    applyWrite(8'h10, 32'hFFFFFFFF, 4'hF, 1'b1, 1'b1);
    collectB("wr_status");
    checkOutput("wr_status_nochg", gpioOut, packModel());
    expectRead(8'h14);
    applyRead(8'h14);
    collectR("rd_unmapped");
    expectWrite(8'h1D, 32'h12345678, 4'hF);
    applyWrite(8'h1D, 32'h12345678, 4'hF, 1'b1, 1'b1);
    collectB("wr_unmapped");

    // B backpressure: second write held until the first response is taken
    bready = 1'b0;
    expectWrite(8'h08, 32'h11111111, 4'hF);
    applyWrite(8'h08, 32'h11111111, 4'hF, 1'b1, 1'b1);
    collectB("bp_a");
    repeat (3) tick();
    checkOutput("bp_a_held", bvalid, 1'b1);
    applyWrite(8'h0C, 32'h22222222, 4'hF, 1'b1, 1'b1);
    tick();
    checkOutput("bp_b_not_committed", gpioOut[127:96], 32'h0);
    checkOutput("bp_b_no_pulse", pulse, 4'h0);
    checkOutput("bp_a_resp_kept", {bvalid, bresp}, 3'b100);
    bready = 1'b1;
    expectWrite(8'h0C, 32'h22222222, 4'hF);
    tick();
    collectB("bp_b");
    checkOutput("bp_b_gpio", gpioOut, packModel());
    checkOutput("bp_b_done", bvalid, 1'b0);

    // Read and commit to the same register on one edge returns the old value
    expectRead(8'h04);
    expectWrite(8'h04, 32'h0BADF00D, 4'hF);
    applyWrite(8'h04, 32'h0BADF00D, 4'hF, 1'b1, 1'b1);
    rready  = 1'b0;
    araddr  = 8'h04;
    arvalid = 1'b1;
    checkOutput("rw_arready", arready, 1'b1);
    tick();
    arvalid = 1'b0;
    collectB("rw_same");
    collectR("rw_same");
    rready = 1'b1;
    tick();
    checkOutput("rw_r_done", rvalid, 1'b0);
    checkOutput("rw_gpio", gpioOut, packModel());

    // Reset with an AW held and a read response pending
    rready  = 1'b0;
    araddr  = 8'h00;
    arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    checkOutput("pre_rst_rvalid", rvalid, 1'b1);
    applyWrite(8'h08, 32'h33333333, 4'hF, 1'b1, 1'b0);
    resetn = 1'b0;
    repeat (2) tick();
    resetn = 1'b1;
    rready = 1'b1;
    for (int i = 0; i < 4; i++) mdl[i] = 32'h0;
    tick(); tick();
    checkOutput("mid_rst_valids", {bvalid, rvalid}, 2'b00);
    checkOutput("mid_rst_gpio", gpioOut, 128'h0);
    applyWrite(8'h08, 32'hCAFE0000, 4'hF, 1'b0, 1'b1);
    repeat (3) tick();
    checkOutput("mid_rst_aw_dropped", bvalid, 1'b0);
    expectWrite(8'h08, 32'hCAFE0000, 4'hF);
    applyWrite(8'h08, 32'hCAFE0000, 4'hF, 1'b1, 1'b0);
    collectB("mid_rst_pair");
    checkOutput("mid_rst_pair_gpio", gpioOut, packModel());

    // Random traffic against the model
    for (int k = 0; k < 12; k++) begin
      idx   = int'($urandom_range(0, 6));
      rAddr = 8'(idx * 4 + int'($urandom_range(0, 3)));
      rData = $urandom;
      rStrb = 4'($urandom);
      expectWrite(rAddr, rData, rStrb);
      applyWrite(rAddr, rData, rStrb, 1'b1, 1'b1);
      collectB("rand_w");
      checkOutput("rand_gpio", gpioOut, packModel());
      idx    = int'($urandom_range(0, 6));
      rAddr  = 8'(idx * 4 + int'($urandom_range(0, 3)));
      gpioIn = $urandom;
      expectRead(rAddr);
      applyRead(rAddr);
      collectR("rand_r");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
